// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and the rotating priority scan for the
// decoder-sequencing round-robin arbiter.
package decoder_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First set request bit scanning ptr, ptr+1, ... with natural 3-bit wrap.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] p
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = p + IDX_W'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_dec.sv
// 3-to-8 decoder with enable: d is one-hot at position a when e is high.
module decoder_rr_arbiter_dec
    import decoder_rr_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    input  logic             e,
    output logic [N_REQ-1:0] d
);

    assign d = e ? (N_REQ'(1) << a) : '0;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving a 3-to-8 decoder from a registered grant index,
// with a per-grant hold timeout and a dead cycle between grants.
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_en,
    output logic             busy
);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] idx_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [N_REQ-1:0] dec_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        hold_n  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    idx_n   = rr_pick(req, ptr);
                    hold_n  = '0;
                    state_n = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_n = hold_cnt + CNT_W'(1);
                // Owner drop and timeout share one release path and one ptr update.
                if (!req[gnt_idx] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    state_n = ST_IDLE;
                    ptr_n   = gnt_idx + IDX_W'(1);
                    hold_n  = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= idx_n;
            hold_cnt <= hold_n;
        end
    end

    assign gnt_en = (state == ST_GRANT);
    assign busy   = gnt_en;

    decoder_rr_arbiter_dec u_dec (
        .a (gnt_idx),
        .e (gnt_en),
        .d (dec_d)
    );

    // Masked explicitly so gnt is zero whenever gnt_en is low, whatever the decoder does.
    assign gnt = dec_d & {N_REQ{gnt_en}};

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed self-checking bench for decoder_rr_arbiter (MAX_HOLD=4).
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_idx;
    logic [7:0] exp_gnt;

    decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_en  (gnt_en),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] i, input logic e);
        check({tag, "_gnt"}, 32'(gnt), 32'(g));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(i));
        check({tag, "_en"}, 32'(gnt_en), 32'(e));
        check({tag, "_busy"}, 32'(busy), 32'(e));
        check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    initial begin
        // 1: reset with all requests high
        rst = 1'b1;
        req = 8'hFF;
        tick();
        tick();
        chk_out("t1_reset", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        req = 8'h00;
        tick();
        chk_out("t1_idle", 8'h00, 3'd0, 1'b0);

        // 2: single request, one-cycle latency, release on drop
        req = 8'h04;
        tick();
        chk_out("t2_grant", 8'h04, 3'd2, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t2_release", 8'h00, 3'd2, 1'b0);

        // 3: full rotation 0..7,0 with owners dropping after two cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_idx = 3'(k % 8);
            exp_gnt = 8'h01 << exp_idx;
            tick();
            chk_out("t3_grant_a", exp_gnt, exp_idx, 1'b1);
            tick();
            chk_out("t3_grant_b", exp_gnt, exp_idx, 1'b1);
            req = 8'hFF & ~exp_gnt;
            tick();
            chk_out("t3_gap", 8'h00, exp_idx, 1'b0);
            req = 8'hFF;
        end

        // 4: hold timeout with two persistent requesters, wrap 7 -> 0
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t4_own0", 8'h01, 3'd0, 1'b1);
        end
        tick();
        chk_out("t4_gap0", 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t4_own7", 8'h80, 3'd7, 1'b1);
        end
        tick();
        chk_out("t4_gap7", 8'h00, 3'd7, 1'b0);
        tick();
        chk_out("t4_wrap0", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t4_end", 8'h00, 3'd0, 1'b0);

        // 5: reset during a grant, then ptr restarts at 0
        req = 8'h20;
        tick();
        chk_out("t5_own5", 8'h20, 3'd5, 1'b1);
        rst = 1'b1;
        tick();
        chk_out("t5_reset", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        req = 8'h21;
        tick();
        chk_out("t5_after_rst", 8'h01, 3'd0, 1'b1);
        req = 8'h20;
        tick();
        chk_out("t5_drop0", 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("t5_own5b", 8'h20, 3'd5, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t5_drop5", 8'h00, 3'd5, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h41;
        tick();
        chk_out("t5_ptr_zero", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t5_end", 8'h00, 3'd0, 1'b0);

        // 6: owner 2 drops while req[3] rises in the same cycle
        req = 8'h04;
        tick();
        chk_out("t6_own2a", 8'h04, 3'd2, 1'b1);
        tick();
        chk_out("t6_own2b", 8'h04, 3'd2, 1'b1);
        req = 8'h08;
        tick();
        chk_out("t6_gap", 8'h00, 3'd2, 1'b0);
        tick();
        chk_out("t6_own3", 8'h08, 3'd3, 1'b1);
        req = 8'h00;
        tick();
        chk_out("t6_end", 8'h00, 3'd3, 1'b0);

        // 7: owner drop coincides with timeout -> single release, ptr = 5
        req = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t7_own4", 8'h10, 3'd4, 1'b1);
        end
        req = 8'h00;
        tick();
        chk_out("t7_release", 8'h00, 3'd4, 1'b0);
        tick();
        chk_out("t7_idle", 8'h00, 3'd4, 1'b0);
        req = 8'h30;
        tick();
        chk_out("t7_next5", 8'h20, 3'd5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
